// File: rtl/output_unloader.sv
// -----------------------------------------------------------------------------
// output_unloader
//
// Reads the finished image back out of the output memory and serialises it
// onto a pixel stream. A start request unloads output_mem_depth words from
// address 0 upward. Each word is split into PIX_PER_WORD pixels, least
// significant byte first.
//
// Per word the sequence is FETCH, WAIT, then PIX_PER_WORD transfers.
// FETCH presents the address. WAIT catches the read data, which the memory
// returns one cycle later. There is no prefetch: each word costs two idle
// cycles on the stream.
//
// Ports
//   clock             system clock, rising edge
//   reset             asynchronous active-high reset
//   start_pulse       one-cycle unload request (ignored unless idle)
//   output_mem_depth  words to unload, sampled with start_pulse
//   output_mem_raddr  registered read address to the output memory
//   output_mem_rdata  read data, valid one cycle after the address
//   pixel_data        current pixel
//   pixel_valid       pixel_data is valid
//   pixel_ready       downstream accepts the pixel
//   pixel_last        final pixel of the image
//   busy              unload in progress
//   done_pulse        one-cycle completion strobe
//   depth_fault       sticky: a start asked for more than 2**ADDR_W words
//   checksum          (OUTPUT_UNLOADER_CHECKSUM_EN only) modulo-2^16 sum of
//                     every pixel transferred since the last start
//
// Optional feature macro: OUTPUT_UNLOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module output_unloader #(
    parameter int WORD_W = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_pulse,
    input  logic [ADDR_W:0]   output_mem_depth,
    output logic [ADDR_W-1:0] output_mem_raddr,
    input  logic [WORD_W-1:0] output_mem_rdata,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              pixel_last,
    output logic              busy,
    output logic              done_pulse,
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              depth_fault
);

    localparam int PIX_PER_WORD = WORD_W / PIX_W;
    localparam int BYTE_W       = $clog2(PIX_PER_WORD);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PIX_PER_WORD - 1);
    // Largest legal depth: every address from 0 to all-ones exactly once.
    localparam logic [ADDR_W:0]   MAX_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state_reg,    state_next;
    logic [ADDR_W-1:0]   raddr_reg,    raddr_next;
    logic [ADDR_W:0]     word_idx_reg, word_idx_next;
    logic [ADDR_W:0]     depth_reg,    depth_next;
    logic [BYTE_W-1:0]   byte_idx_reg, byte_idx_next;
    logic [WORD_W-1:0]   shift_reg,    shift_next;
    logic                done_reg,     done_next;
    logic                fault_reg,    fault_next;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
    logic [15:0]         csum_reg,     csum_next;
`endif

    logic                last_word;
    logic                transfer;
    logic [ADDR_W:0]     word_idx_inc;

    assign last_word    = (word_idx_reg == depth_reg - 1'b1);
    assign transfer     = (state_reg == S_STREAM) && pixel_ready;
    assign word_idx_inc = word_idx_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        raddr_next    = raddr_reg;
        word_idx_next = word_idx_reg;
        depth_next    = depth_reg;
        byte_idx_next = byte_idx_reg;
        shift_next    = shift_reg;
        done_next     = 1'b0;
        fault_next    = fault_reg;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (start_pulse) begin
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
                    csum_next = '0;
`endif
                    if (output_mem_depth == '0) begin
                        // Empty image: complete immediately, no reads.
                        done_next  = 1'b1;
                        fault_next = 1'b0;
                    end else if (output_mem_depth > MAX_DEPTH) begin
                        // Would wrap the address space: refuse, flag, finish.
                        done_next  = 1'b1;
                        fault_next = 1'b1;
                    end else begin
                        depth_next    = output_mem_depth;
                        word_idx_next = '0;
                        raddr_next    = '0;
                        fault_next    = 1'b0;
                        state_next    = S_FETCH;
                    end
                end
            end

            // The address was registered on the edge entering FETCH, so
            // the memory sees it for the whole of this cycle.
            S_FETCH: state_next = S_WAIT;

            S_WAIT: begin
                shift_next    = output_mem_rdata;
                byte_idx_next = '0;
                state_next    = S_STREAM;
            end

            S_STREAM: begin
                if (transfer) begin
                    shift_next    = shift_reg >> PIX_W;
                    byte_idx_next = byte_idx_reg + 1'b1;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
                    csum_next     = csum_reg + 16'(shift_reg[PIX_W-1:0]);
`endif
                    if (byte_idx_reg == LAST_BYTE) begin
                        if (last_word) begin
                            done_next  = 1'b1;
                            state_next = S_DONE;
                        end else begin
                            word_idx_next = word_idx_inc;
                            raddr_next    = word_idx_inc[ADDR_W-1:0];
                            state_next    = S_FETCH;
                        end
                    end
                end
            end

            S_DONE: state_next = S_IDLE;

            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            raddr_reg    <= '0;
            word_idx_reg <= '0;
            depth_reg    <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            done_reg     <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            raddr_reg    <= raddr_next;
            word_idx_reg <= word_idx_next;
            depth_reg    <= depth_next;
            byte_idx_reg <= byte_idx_next;
            shift_reg    <= shift_next;
            done_reg     <= done_next;
            fault_reg    <= fault_next;
        end
    end

`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_reg <= '0;
        end else begin
            csum_reg <= csum_next;
        end
    end

    assign checksum = csum_reg;
`endif

    assign output_mem_raddr = raddr_reg;
    // The shift register only moves on a transfer, so data holds under
    // back-pressure and is all-zero whenever nothing is streaming.
    assign pixel_data       = shift_reg[PIX_W-1:0];
    assign pixel_valid      = (state_reg == S_STREAM);
    assign pixel_last       = (state_reg == S_STREAM) && (byte_idx_reg == LAST_BYTE) && last_word;
    assign busy             = (state_reg != S_IDLE);
    assign done_pulse       = done_reg;
    assign depth_fault      = fault_reg;

endmodule

// File: doc/output_unloader.md
Name: output_unloader

Overview:
- Reader at the far end of the output memory. The equalizer core writes that memory; this block reads it back.
- On a start pulse (driven from image_done_pulse), it reads output_mem_depth 128-bit words from address 0 upward.
- Each word is serialised into 16 8-bit equalized pixels on a valid/ready stream toward the chip output interface.
- It fills the output-side slot next to top_without_mem, mirroring how the input side loads the input memory.

Parameters:
- WORD_W, 128, memory word width in bits.
- PIX_W, 8, pixel width in bits; PIX_PER_WORD = WORD_W/PIX_W = 16.
- ADDR_W, 16, memory address width.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start_pulse  input  1  one-cycle request to unload the image.
- output_mem_depth  input  17  number of words to unload; sampled on accepted start_pulse.
- output_mem_raddr  output  16  read address to output memory.
- output_mem_rdata  input  128  read data; valid exactly one cycle after raddr is presented.
- pixel_data  output  8  current pixel.
- pixel_valid  output  1  pixel_data is valid.
- pixel_ready  input  1  downstream accepts; transfer occurs when pixel_valid && pixel_ready.
- pixel_last  output  1  marks the final pixel of the image.
- busy  output  1  high from the cycle after an accepted start until done.
- done_pulse  output  1  one-cycle pulse on completion.
- depth_fault  output  1  sticky; set when the sampled depth exceeds 65536.

Behaviour:
- Reset values (asynchronous): state=IDLE; raddr=0; pixel_data=0; pixel_valid=0; pixel_last=0; busy=0; done_pulse=0; depth_fault=0; counters and shift register=0.
- State IDLE:
  - start_pulse=1 with depth in 1..65536: latch depth, word_idx=0, go to FETCH.
  - Depth=0: pulse done_pulse the next cycle; stay IDLE.
  - Depth>65536: set depth_fault, pulse done_pulse the next cycle, no memory reads, stay IDLE.
- State FETCH: drive output_mem_raddr = word_idx (registered); go to WAIT.
- State WAIT: at the clock edge ending this cycle, load output_mem_rdata into the 128-bit shift register; byte_idx=0; go to STREAM.
- State STREAM:
  - pixel_valid=1; pixel_data = shift[7:0]; pixel 0 of a word is rdata[7:0], pixel 15 is rdata[127:120].
  - On each transfer, shift right 8 and increment byte_idx.
  - When pixel_valid && !pixel_ready, pixel_data and pixel_last hold stable.
  - pixel_last=1 only when byte_idx=15 and word_idx=depth-1.
  - Transfer at byte_idx=15, not last word: word_idx+1, go to FETCH.
  - Transfer at byte_idx=15, last word: go to DONE.
- State DONE: done_pulse=1 for one cycle; busy=0 from the next cycle; go to IDLE.
- Latency:
  - start accepted at edge N → raddr=0 valid in cycle N+1 → first pixel_valid in cycle N+3.
  - Each word costs 2 non-streaming cycles (FETCH, WAIT) plus 16 transfer cycles. No prefetch.
  - With ready tied high, total = 18*depth cycles from start to the last transfer; done_pulse follows one cycle after that transfer.
- start_pulse while not IDLE is ignored; no restart and no queueing.
- pixel_ready is ignored outside STREAM; pixel_valid is never asserted outside STREAM.
- Address arithmetic: word_idx is 17 bits internally; raddr = word_idx[15:0]. Max depth 65536 reaches address 0xFFFF and no wrap is ever issued.
- depth_fault clears only on reset or on the next accepted start with a legal depth.
- Reset mid-operation: asynchronous abort to IDLE; no done_pulse; partial stream is discarded.

Optional Feature:
- Macro OUTPUT_UNLOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [15:0].
  - Running modulo-2^16 sum of every transferred pixel; cleared on accepted start.
  - Final value is stable and valid in the cycle done_pulse is high, and holds until the next start.
  - Depth=0 or a depth_fault start gives checksum=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single word, bytes 0x00..0x0F: depth=1, rdata=128'h0F0E...0100, ready=1 → pixels 0x00..0x0F in order; pixel_last on 0x0F only; raddr=0; done_pulse one cycle after the last transfer; checksum=0x0078.
- Throughput: depth=3, ready=1 → 48 transfers over 54 cycles from start; raddr sequence 0,1,2; two-cycle bubble between words.
- Backpressure: depth=2, ready toggling 1,0,0,1 → no pixel lost or duplicated; data held during ready=0; 32 transfers total.
- Edge depths: depth=0 → done_pulse next cycle, pixel_valid never 1. depth=65537 → depth_fault=1, done_pulse, no reads. depth=65536 → last raddr=0xFFFF.
- Start while busy: second start_pulse mid-stream of depth=2 → ignored; exactly 32 pixels and one done_pulse.
- Reset mid-stream at pixel 5 of word 0 → all outputs return to reset values in the same cycle, no done_pulse; a new start of depth=1 then unloads normally.
